// File: rtl/strip_bank_sched_if.sv
// ============================================================================
// strip_bank_sched_if : handshake bundle between strip-bank scheduler, DVP write side and DCT read side
// Rev 1.0
// ============================================================================
`default_nettype none

interface strip_bank_sched_if #(
    parameter int NUM_BANKS = 2
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                 frame_start;
    logic                 wr_done;
    logic [BANK_W-1:0]    wr_bank;
    logic                 wr_allow;
    logic                 rd_start;
    logic                 rd_abort;
    logic [BANK_W-1:0]    rd_bank;
    logic                 rd_busy;
    logic                 rd_done;
    logic                 dst_ready;
    logic [NUM_BANKS-1:0] full_mask;
    logic [7:0]           strip_cnt;
    logic                 frame_done;
    logic                 overflow;

    // Scheduler side
    modport slave (
        input  frame_start, wr_done, rd_done, dst_ready,
        output wr_bank, wr_allow, rd_start, rd_abort, rd_bank, rd_busy,
               full_mask, strip_cnt, frame_done, overflow
    );

    // Capture / address-generator side
    modport master (
        output frame_start, wr_done, rd_done, dst_ready,
        input  wr_bank, wr_allow, rd_start, rd_abort, rd_bank, rd_busy,
               full_mask, strip_cnt, frame_done, overflow
    );
endinterface

`default_nettype wire

// File: rtl/strip_bank_sched.sv
// ============================================================================
// strip_bank_sched : tracks full strip banks, steers the write bank and issues oldest-first reads
// Rev 1.0
// ============================================================================
`default_nettype none

module strip_bank_sched #(
    parameter int NUM_BANKS        = 2,
    parameter int STRIPS_PER_FRAME = 90
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    strip_bank_sched_if.slave   bus
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANKS - 1);
    localparam logic [7:0]        LAST_STRIP = 8'(STRIPS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_SCAN    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_BANKS-1:0] full_q, full_d;
    logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
    logic [7:0]           strip_cnt_q, strip_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 rd_abort_q, rd_abort_d;
    logic                 frame_done_q, frame_done_d;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            full_q       <= '0;
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            strip_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            rd_abort_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            strip_cnt_q  <= strip_cnt_d;
            overflow_q   <= overflow_d;
            rd_abort_q   <= rd_abort_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        strip_cnt_d  = strip_cnt_q;
        overflow_d   = overflow_q;
        rd_abort_d   = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q] && bus.dst_ready) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (bus.rd_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d             = ST_IDLE;
                full_d[rd_bank_q]   = 1'b0;
                rd_bank_d           = bank_inc(rd_bank_q);
                if (strip_cnt_q == LAST_STRIP) begin
                    strip_cnt_d  = '0;
                    frame_done_d = 1'b1;
                end else begin
                    strip_cnt_d  = strip_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Uses the registered flag, so a bank being released this cycle still counts as full
        if (bus.wr_done) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = bank_inc(wr_bank_q);
            end
        end

        // Frame restart overrides everything except the sticky overflow flag
        if (bus.frame_start) begin
            state_d      = ST_IDLE;
            full_d       = '0;
            wr_bank_d    = '0;
            rd_bank_d    = '0;
            strip_cnt_d  = '0;
            overflow_d   = overflow_q;
            frame_done_d = 1'b0;
            rd_abort_d   = (state_q == ST_START) || (state_q == ST_SCAN);
        end
    end

    assign bus.wr_bank    = wr_bank_q;
    assign bus.wr_allow   = ~full_q[wr_bank_q];
    assign bus.rd_start   = (state_q == ST_START);
    assign bus.rd_busy    = (state_q == ST_SCAN);
    assign bus.rd_abort   = rd_abort_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.full_mask  = full_q;
    assign bus.strip_cnt  = strip_cnt_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_strip_bank_sched.sv
// ============================================================================
// tb_strip_bank_sched : directed + random checks of strip_bank_sched against a fill-order queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_strip_bank_sched;
    localparam int NB  = 2;
    localparam int SPF = 4;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    strip_bank_sched_if #(.NUM_BANKS(NB)) bus ();

    strip_bank_sched #(
        .NUM_BANKS       (NB),
        .STRIPS_PER_FRAME(SPF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full banks held as a queue in fill order; write pointer is
    // the slot just past the newest full bank.
    int m_q[$];
    int m_rdb;
    int m_phase;   // 0 idle, 1 start, 2 scan, 3 release
    int m_cnt;
    bit m_ovf, m_fdone, m_abort;

    function automatic int m_mask();
        int m = 0;
        foreach (m_q[i]) m |= (1 << m_q[i]);
        return m;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rdb = 0; m_phase = 0; m_cnt = 0;
        m_ovf = 0; m_fdone = 0; m_abort = 0;
    endtask

    task automatic model_adv(input bit fs, input bit wd, input bit rdn, input bit rdy);
        int sz  = m_q.size();
        int wrb = (m_rdb + sz) % NB;
        int ph  = m_phase;
        m_abort = 0;
        m_fdone = 0;
        if (fs) begin
            m_abort = (ph == 1 || ph == 2);
            m_q.delete();
            m_rdb = 0; m_cnt = 0; m_phase = 0;
            return;
        end
        case (ph)
            0: if (sz > 0 && rdy) m_phase = 1;
            1: m_phase = 2;
            2: if (rdn) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (ph == 3) begin
            m_q.delete(0);
            m_rdb = (m_rdb + 1) % NB;
            if (m_cnt == SPF - 1) begin
                m_cnt = 0; m_fdone = 1;
            end else begin
                m_cnt++;
            end
        end
        if (wd) begin
            if (sz == NB) m_ovf = 1;
            else          m_q.push_back(wrb);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_assert++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("wr_bank",    32'(bus.wr_bank),    (m_rdb + m_q.size()) % NB);
        check("wr_allow",   32'(bus.wr_allow),   (m_q.size() < NB) ? 1 : 0);
        check("rd_start",   32'(bus.rd_start),   (m_phase == 1) ? 1 : 0);
        check("rd_busy",    32'(bus.rd_busy),    (m_phase == 2) ? 1 : 0);
        check("rd_abort",   32'(bus.rd_abort),   int'(m_abort));
        check("rd_bank",    32'(bus.rd_bank),    m_rdb);
        check("full_mask",  32'(bus.full_mask),  m_mask());
        check("strip_cnt",  32'(bus.strip_cnt),  m_cnt);
        check("frame_done", 32'(bus.frame_done), int'(m_fdone));
        check("overflow",   32'(bus.overflow),   int'(m_ovf));
    endtask

    // One clock: check outputs mid-cycle, drive inputs, advance model on the edge
    task automatic step(input bit fs, input bit wd, input bit rdn, input bit rdy);
        @(negedge clk);
        check_all();
        bus.frame_start = fs;
        bus.wr_done     = wd;
        bus.rd_done     = rdn;
        bus.dst_ready   = rdy;
        @(posedge clk);
        model_adv(fs, wd, rdn, rdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.frame_start = 0; bus.wr_done = 0; bus.rd_done = 0; bus.dst_ready = 0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_full_mask",  32'(bus.full_mask),  0);
        check("rst_wr_bank",    32'(bus.wr_bank),    0);
        check("rst_rd_bank",    32'(bus.rd_bank),    0);
        check("rst_strip_cnt",  32'(bus.strip_cnt),  0);
        check("rst_overflow",   32'(bus.overflow),   0);
        check("rst_rd_start",   32'(bus.rd_start),   0);
        check("rst_rd_abort",   32'(bus.rd_abort),   0);
        check("rst_rd_busy",    32'(bus.rd_busy),    0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_wr_allow",   32'(bus.wr_allow),   1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_busy();
        int k = 0;
        while (bus.rd_busy !== 1'b1 && k < 20) begin
            step(0, 0, 0, 1);
            k++;
        end
        check("wait_busy", 32'(bus.rd_busy), 1);
    endtask

    task automatic wait_start();
        int k = 0;
        while (bus.rd_start !== 1'b1 && k < 20) begin
            step(0, 0, 0, 1);
            k++;
        end
        check("wait_start", 32'(bus.rd_start), 1);
    endtask

    // Fill the current write bank and read it back completely
    task automatic one_strip();
        step(0, 1, 0, 1);
        wait_busy();
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_seen;
        rst_n = 1'b0;
        bus.frame_start = 0; bus.wr_done = 0; bus.rd_done = 0; bus.dst_ready = 0;
        do_reset();

        // Idle: nothing happens for 100 cycles
        repeat (100) step(0, 0, 0, 0);
        check("idle_wr_allow", 32'(bus.wr_allow), 1);

        // Single strip with fixed latencies
        step(0, 1, 0, 1);
        check("s1_full",    32'(bus.full_mask), 1);
        check("s1_wr_bank", 32'(bus.wr_bank),   1);
        step(0, 0, 0, 1);
        check("s1_rd_start", 32'(bus.rd_start), 1);
        check("s1_rd_bank",  32'(bus.rd_bank),  0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        check("s1_full_hold", 32'(bus.full_mask), 1);
        step(0, 0, 0, 1);
        check("s1_full_clr", 32'(bus.full_mask), 0);
        check("s1_cnt",      32'(bus.strip_cnt), 1);

        // Write into bank 1 in the same cycle bank 0 is released
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 1, 0, 1);
        check("same_full", 32'(bus.full_mask), 2);
        check("same_ovf",  32'(bus.overflow),  0);
        check("same_rdb",  32'(bus.rd_bank),   1);

        // Frame wrap after SPF strips
        step(1, 0, 0, 0);
        fd_seen = 0;
        for (int i = 0; i < SPF; i++) begin
            one_strip();
            if (bus.frame_done === 1'b1) fd_seen++;
        end
        check("wrap_fd_now", 32'(bus.frame_done), 1);
        check("wrap_cnt",    32'(bus.strip_cnt),  0);
        check("wrap_fd_cnt", 32'(fd_seen),        1);
        step(0, 0, 0, 0);
        check("wrap_fd_low", 32'(bus.frame_done), 0);

        // Overflow with reads held off, then oldest-first draining
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("ovf_full",    32'(bus.full_mask), 3);
        check("ovf_flag",    32'(bus.overflow),  1);
        check("ovf_wr_bank", 32'(bus.wr_bank),   0);
        for (int i = 0; i < NB; i++) begin
            wait_start();
            check("ovf_order", 32'(bus.rd_bank), i);
            step(0, 0, 0, 1);
            step(0, 0, 1, 1);
            step(0, 0, 0, 1);
        end

        // Abort during a scan of bank 1
        step(1, 0, 0, 0);
        one_strip();
        step(0, 1, 0, 1);
        wait_busy();
        check("abt_rdb_pre", 32'(bus.rd_bank), 1);
        step(1, 0, 0, 1);
        check("abt_pulse", 32'(bus.rd_abort),  1);
        check("abt_busy",  32'(bus.rd_busy),   0);
        check("abt_full",  32'(bus.full_mask), 0);
        check("abt_wrb",   32'(bus.wr_bank),   0);
        check("abt_rdb",   32'(bus.rd_bank),   0);
        check("abt_ovf",   32'(bus.overflow),  1);
        step(0, 0, 0, 0);
        check("abt_low",   32'(bus.rd_abort),  0);

        // Random traffic against the model
        repeat (3000) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        do_reset();
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
